// File: rtl/relay_sched_pkg.sv
// -----------------------------------------------------------------------------
// relay_sched_pkg
// Shared relay definitions: frame state encoding, the 400-bit test pattern,
// the preamble pattern and the simulate-mode codes that select pattern frames.
// -----------------------------------------------------------------------------
package relay_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_GUARD    = 2'd3
    } relay_state_e;

    localparam int         PAT_BITS = 400;
    localparam logic [8:0] PAT_LAST = 9'd399;

    // Emitted MSB (bit 399) first.
    localparam logic [399:0] TEST_PATTERN =
        400'hF0E1D2C3B4A5968778695A4B3C2D1E0F_0123456789ABCDEFFEDCBA9876543210_DEADBEEFCAFEBABE8BADF00D13579BDF_2468;

    localparam logic [7:0] PREAMBLE_PATTERN = 8'b1111_0000;

    localparam logic [2:0] MODE_FAKE_READER = 3'b100;
    localparam logic [2:0] MODE_FAKE_TAG    = 3'b101;

    function automatic logic is_fake_mode(input logic [2:0] mode);
        return (mode == MODE_FAKE_READER) || (mode == MODE_FAKE_TAG);
    endfunction

    // Bit counters hold at all-ones instead of wrapping.
    function automatic logic [8:0] sat_inc9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

endpackage

// File: rtl/relay_sched_if.sv
// -----------------------------------------------------------------------------
// relay_sched_if
// Groups the relay scheduler's mode/requester inputs and encoder-side outputs.
//   master : drives hi_simulate_mod_type, live_req, relay_raw
//   slave  : the scheduler; drives live_gnt, enc_bit, enc_dir, dec_en,
//            bit_strobe, frame_active, frame_done
// -----------------------------------------------------------------------------
interface relay_sched_if;
    logic [2:0] hi_simulate_mod_type;
    logic       live_req;
    logic       relay_raw;
    logic       live_gnt;
    logic       enc_bit;
    logic       enc_dir;
    logic       dec_en;
    logic       bit_strobe;
    logic       frame_active;
    logic       frame_done;

    modport master (
        output hi_simulate_mod_type, live_req, relay_raw,
        input  live_gnt, enc_bit, enc_dir, dec_en, bit_strobe, frame_active, frame_done
    );

    modport slave (
        input  hi_simulate_mod_type, live_req, relay_raw,
        output live_gnt, enc_bit, enc_dir, dec_en, bit_strobe, frame_active, frame_done
    );
endinterface

// File: rtl/relay_bitclk.sv
// -----------------------------------------------------------------------------
// relay_bitclk
// Free-running 4-bit divider; one bit slot every 16 clocks.
//   i_clk        : system clock
//   i_reset_n    : asynchronous active-low reset (divider to 0)
//   o_bit_strobe : high while the divider reads 4'b1000, so the first slot
//                  edge after reset release is the 9th rising clock
// -----------------------------------------------------------------------------
module relay_bitclk (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_bit_strobe
);
    logic [3:0] r_div;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div <= 4'd0;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    assign o_bit_strobe = (r_div == 4'b1000);
endmodule

// File: rtl/relay_sched.sv
// -----------------------------------------------------------------------------
// relay_sched
// Schedules relay encoder frames: preamble, payload from either the built-in
// test pattern or the live requester, then a zero guard. Pattern requests (a
// fake simulate mode) win over live_req when both are present at a slot edge.
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : relay_sched_if.slave (mode, live_req/relay_raw in; encoder
//           outputs, live_gnt, bit_strobe, frame_active, frame_done out)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no frame; enc_bit 0; waiting for a request at a slot edge
// PREAMBLE | PRE_BITS slots of 11110000, MSB first
// PAYLOAD  | pattern bits (persistent rotation) or sampled relay_raw
// GUARD    | GUARD_BITS zero slots, then frame_done and back to IDLE
// -----------------------------------------------------------------------------
module relay_sched
    import relay_sched_pkg::*;
#(
    parameter int PRE_BITS   = 8,
    parameter int GUARD_BITS = 4,
    parameter int LIVE_MAX   = 255
) (
    input  logic         clk,
    input  logic         reset,
    relay_sched_if.slave bus
);
    localparam logic [8:0] PRE_LEN   = 9'(PRE_BITS);
    localparam logic [8:0] GUARD_LEN = 9'(GUARD_BITS);
    localparam logic [8:0] LIVE_LEN  = 9'(LIVE_MAX);
    localparam logic [8:0] PAT_LEN   = 9'(PAT_BITS);

    relay_state_e r_state;
    relay_state_e w_state_nxt;
    logic [8:0]   r_cnt;
    logic [8:0]   w_cnt_nxt;
    logic [8:0]   r_ptr;
    logic         r_enc_bit;
    logic         w_enc_nxt;
    logic         r_src_live;
    logic         r_enc_dir;
    logic         r_dec_en;
    logic         r_frame_done;
    logic         w_done_nxt;
    logic         w_ptr_adv;
    logic         w_strobe;
    logic         w_is_fake;
    logic         w_hold;
    logic         w_start;
    logic [8:0]   w_pay_len;
    logic [2:0]   w_pre_idx;

    relay_bitclk u_bitclk (
        .i_clk        (clk),
        .i_reset_n    (reset),
        .o_bit_strobe (w_strobe)
    );

    assign w_is_fake = is_fake_mode(bus.hi_simulate_mod_type);
    // The latched source decides what keeps a payload going.
    assign w_hold    = r_src_live ? bus.live_req : w_is_fake;
    assign w_pay_len = r_src_live ? LIVE_LEN : PAT_LEN;
    assign w_start   = w_strobe && (r_state == ST_IDLE) && (w_state_nxt == ST_PREAMBLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_strobe) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_fake || bus.live_req) begin
                        w_state_nxt = ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (r_cnt >= PRE_LEN) begin
                        w_state_nxt = w_hold ? ST_PAYLOAD : ST_GUARD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!w_hold || (r_cnt >= w_pay_len)) begin
                        w_state_nxt = ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (r_cnt >= GUARD_LEN) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // r_cnt is the number of slots already emitted in the current state,
    // including the one being driven now; the next slot's bit is chosen here.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_enc_nxt  = r_enc_bit;
        w_ptr_adv  = 1'b0;
        w_done_nxt = 1'b0;
        w_pre_idx  = 3'd0;
        if (w_strobe) begin
            w_enc_nxt = 1'b0;
            if (w_state_nxt == ST_IDLE) begin
                w_cnt_nxt = 9'd0;
            end else if (w_state_nxt != r_state) begin
                w_cnt_nxt = 9'd1;
            end else begin
                w_cnt_nxt = sat_inc9(r_cnt);
            end
            w_pre_idx = 3'(w_cnt_nxt - 9'd1);
            case (w_state_nxt)
                ST_PREAMBLE: w_enc_nxt = PREAMBLE_PATTERN[~w_pre_idx];
                ST_PAYLOAD: begin
                    if (r_src_live) begin
                        w_enc_nxt = bus.relay_raw;
                    end else begin
                        w_enc_nxt = TEST_PATTERN[r_ptr];
                        w_ptr_adv = 1'b1;
                    end
                end
                default: w_enc_nxt = 1'b0;
            endcase
            w_done_nxt = (r_state == ST_GUARD) && (w_state_nxt == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= 9'd0;
            r_ptr        <= PAT_LAST;
            r_enc_bit    <= 1'b0;
            r_src_live   <= 1'b0;
            r_enc_dir    <= 1'b0;
            r_dec_en     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_enc_bit    <= w_enc_nxt;
            r_frame_done <= w_done_nxt;
            // Pointer walks 399 -> 0 and wraps; it survives between frames.
            if (w_ptr_adv) begin
                r_ptr <= (r_ptr == 9'd0) ? PAT_LAST : r_ptr - 9'd1;
            end
            if (w_start) begin
                r_src_live <= !w_is_fake;
                r_enc_dir  <= (bus.hi_simulate_mod_type == MODE_FAKE_READER);
                r_dec_en   <= (bus.hi_simulate_mod_type == MODE_FAKE_READER);
            end else if (w_strobe && (w_state_nxt == ST_IDLE)) begin
                r_src_live <= 1'b0;
                r_enc_dir  <= 1'b0;
                r_dec_en   <= 1'b0;
            end
        end
    end

    assign bus.enc_bit      = r_enc_bit;
    assign bus.live_gnt     = r_src_live && ((r_state == ST_PREAMBLE) || (r_state == ST_PAYLOAD));
    assign bus.enc_dir      = r_enc_dir;
    assign bus.dec_en       = r_dec_en;
    assign bus.bit_strobe   = w_strobe;
    assign bus.frame_active = (r_state != ST_IDLE);
    assign bus.frame_done   = r_frame_done;

endmodule

// File: tb/tb_relay_sched.sv
`timescale 1ns/1ps
module tb_relay_sched;
    localparam logic [2:0] M_READER = 3'b100;
    localparam logic [2:0] M_TAG    = 3'b101;
    localparam logic [399:0] T_PAT =
        400'hF0E1D2C3B4A5968778695A4B3C2D1E0F_0123456789ABCDEFFEDCBA9876543210_DEADBEEFCAFEBABE8BADF00D13579BDF_2468;
    localparam logic [7:0] T_PRE = 8'b1111_0000;

    // want = {enc_bit, live_gnt, enc_dir, dec_en, frame_active, frame_done}
    // after the slot edge; mode/lr/raw are driven before that edge.
    typedef struct packed {
        logic [2:0] mode;
        logic       lr;
        logic       raw;
        logic [5:0] want;
    } slot_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    relay_sched_if rif ();

    relay_sched #(.PRE_BITS(8), .GUARD_BITS(4), .LIVE_MAX(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rif)
    );

    int           checks   = 0;
    int           failures = 0;
    int           slot_no  = 0;
    slot_t        plan[$];
    slot_t        sb[$];
    logic [399:0] m_pat;       // rotating image: bit 399 is the next pattern bit
    logic [7:0]   pre;

    function automatic logic [2:0] other_mode();
        logic [2:0] v;
        v = 3'($urandom_range(0, 5));
        if (v >= 3'd4) v = v + 3'd2;
        return v;
    endfunction

    function automatic slot_t mk(logic [2:0] mode, logic lr, logic raw,
                                 logic b, logic g, logic d, logic act, logic done);
        slot_t s;
        s.mode = mode;
        s.lr   = lr;
        s.raw  = raw;
        s.want = {b, g, d, d, act, done};
        return s;
    endfunction

    function automatic void add_idle(int n);
        for (int k = 0; k < n; k++)
            plan.push_back(mk(other_mode(), 1'b0, 1'($urandom), 0, 0, 0, 0, 0));
    endfunction

    // drop == 0: full 400-bit payload; otherwise mode leaves after 'drop' bits.
    function automatic void add_pattern(logic [2:0] mode, logic lr, int drop);
        logic       d;
        logic [2:0] gm;
        int         n;
        d  = (mode == M_READER);
        n  = (drop == 0) ? 400 : drop;
        gm = (drop == 0) ? mode : other_mode();
        for (int k = 0; k < 8; k++)
            plan.push_back(mk(mode, lr, 1'($urandom), pre[7-k], 0, d, 1, 0));
        for (int k = 0; k < n; k++) begin
            plan.push_back(mk(mode, lr, 1'($urandom), m_pat[399], 0, d, 1, 0));
            m_pat = {m_pat[398:0], m_pat[399]};
        end
        for (int k = 0; k < 4; k++)
            plan.push_back(mk(gm, lr, 1'($urandom), 0, 0, d, 1, 0));
        plan.push_back(mk(gm, lr, 1'($urandom), 0, 0, 0, 0, 1));
    endfunction

    // live_req held for 'len' payload slots (capped at 255); kind 0 alternating,
    // 1 all ones, 2 random data.
    function automatic void add_live(int len, int kind);
        logic [2:0] m;
        logic       raw;
        int         n;
        m = other_mode();
        n = (len > 255) ? 255 : len;
        for (int k = 0; k < 8; k++)
            plan.push_back(mk(m, 1'b1, 1'($urandom), pre[7-k], 1, 0, 1, 0));
        for (int k = 0; k < n; k++) begin
            raw = (kind == 0) ? ((k % 2) == 0) : (kind == 1) ? 1'b1 : 1'($urandom);
            plan.push_back(mk(m, 1'b1, raw, raw, 1, 0, 1, 0));
        end
        plan.push_back(mk(m, (len > 255), 1'($urandom), 0, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++)
            plan.push_back(mk(m, 1'b0, 1'($urandom), 0, 0, 0, 1, 0));
        plan.push_back(mk(m, 1'b0, 1'($urandom), 0, 0, 0, 0, 1));
    endfunction

    task automatic wait_strobe();
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (rif.bit_strobe === 1'b1) break;
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL strobe_timeout: no bit_strobe in 40 clk, required one every 16");
            sb.delete();
        end else begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input slot_t s);
        rif.hi_simulate_mod_type = s.mode;
        rif.live_req             = s.lr;
        rif.relay_raw            = s.raw;
        sb.push_back(s);
    endtask

    task automatic run_plan(input int limit);
        for (int i = 0; i < plan.size() && i < limit; i++) begin
            drive(plan[i]);
            wait_strobe();
        end
        plan.delete();
    endtask

    task automatic check_zero(input string name);
        logic [6:0] act;
        act = {rif.enc_bit, rif.live_gnt, rif.enc_dir, rif.dec_en,
               rif.bit_strobe, rif.frame_active, rif.frame_done};
        checks++;
        if (act !== 7'd0) begin
            failures++;
            $display("FAIL %s: outputs %b, required 0000000", name, act);
        end
    endtask

    // Drives the first planned slot while still in reset, releases reset,
    // checks the first slot edge is the 9th rising clk, then runs the plan.
    task automatic start_after_reset();
        int   n;
        logic found;
        drive(plan.pop_front());
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        found = 1'b0;
        while (n < 30 && !found) begin
            @(posedge clk);
            n++;
            #1;
            if (rif.bit_strobe === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || n != 8) begin
            failures++;
            $display("FAIL first_strobe: strobe acts on edge %0d, required edge 9", n + 1);
        end
        wait_strobe();
        run_plan(plan.size());
    endtask

    // Scoreboard monitor: one expected entry per slot edge.
    initial begin
        slot_t      s;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (rif.bit_strobe === 1'b1) begin
                @(posedge clk);
                #1;
                act = {rif.enc_bit, rif.live_gnt, rif.enc_dir, rif.dec_en,
                       rif.frame_active, rif.frame_done};
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: outputs %b with no slot planned", act);
                end else begin
                    s = sb.pop_front();
                    if (act !== s.want) begin
                        failures++;
                        $display("FAIL slot %0d: got %b required %b (bit gnt dir dec act done)",
                                 slot_no, act, s.want);
                    end
                    if (s.want[0]) begin
                        @(posedge clk);
                        #1;
                        checks++;
                        if (rif.frame_done !== 1'b0) begin
                            failures++;
                            $display("FAIL done_width: frame_done %b one clk later, required 0",
                                     rif.frame_done);
                        end
                    end
                end
                slot_no++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        m_pat = T_PAT;
        pre   = T_PRE;
        rif.hi_simulate_mod_type = 3'd0;
        rif.live_req  = 1'b0;
        rif.relay_raw = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");

        // Full reader frame straight out of reset.
        add_pattern(M_READER, 1'b0, 0);
        start_after_reset();

        // Tag mode and live_req at the same edge: pattern wins.
        add_idle(2);
        add_pattern(M_TAG, 1'b1, 0);
        run_plan(plan.size());

        // Live frames: 20 alternating bits, then the 255-bit cap.
        add_idle(2);
        add_live(20, 0);
        add_idle(1);
        add_live(300, 1);
        add_idle(2);
        run_plan(plan.size());

        // Mode dropped after 100 bits; the next frame resumes at bit 299.
        add_pattern(M_READER, 1'b0, 100);
        add_idle(1);
        add_pattern(M_TAG, 1'b0, int'($urandom_range(1, 50)));
        run_plan(plan.size());

        // Randomised mix, including back-to-back frames.
        for (int f = 0; f < 6; f++) begin
            case ($urandom_range(0, 2))
                0:       add_live(int'($urandom_range(1, 40)), 2);
                1:       add_pattern(M_READER, 1'b0, int'($urandom_range(1, 60)));
                default: add_pattern(M_TAG, 1'($urandom), int'($urandom_range(1, 60)));
            endcase
            add_idle(int'($urandom_range(0, 2)));
        end
        run_plan(plan.size());

        // Reset in the middle of a pattern payload.
        add_pattern(M_READER, 1'b0, 60);
        run_plan(8 + 25);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("midframe_reset_immediate");
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if ({rif.enc_bit, rif.live_gnt, rif.enc_dir, rif.dec_en, rif.bit_strobe,
                 rif.frame_active, rif.frame_done} !== 7'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL midframe_reset_hold: nonzero output or frame_done during reset, required all 0");
        end
        m_pat = T_PAT;
        add_pattern(M_TAG, 1'b0, 30);
        start_after_reset();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d slots left, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/relay_sched.md
RELAY_SCHED -- requirements
Module: relay_sched

Interface
REQ-001 SHALL have parameter PRE_BITS, default 8: preamble length in bit slots.
REQ-002 SHALL have parameter GUARD_BITS, default 4: guard length in bit slots.
REQ-003 SHALL have parameter LIVE_MAX, default 255: maximum live payload length in bit slots.
REQ-004 SHALL have port clk  in  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port hi_simulate_mod_type  in  3  simulate mode; FAKE_READER/FAKE_TAG codes from the shared mode header.
REQ-007 SHALL have port live_req  in  1  live requester wants the encoder (level).
REQ-008 SHALL have port relay_raw  in  1  live requester data bit.
REQ-009 SHALL have port live_gnt  out  1  live requester owns the current frame.
REQ-010 SHALL have port enc_bit  out  1  bit to relay encoder.
REQ-011 SHALL have port enc_dir  out  1  encoder direction; 1 = reader side.
REQ-012 SHALL have port dec_en  out  1  decoder enable for reader-side decode.
REQ-013 SHALL have port bit_strobe  out  1  one-clk pulse per bit slot.
REQ-014 SHALL have port frame_active  out  1  high from PREAMBLE through GUARD.
REQ-015 SHALL have port frame_done  out  1  one-clk pulse on GUARD->IDLE.

Function
REQ-016 SHALL run a free 4-bit divider; bit_strobe SHALL pulse when the divider equals 4'b1000 (every 16 clk, wraps 15->0).
REQ-017 SHALL implement states IDLE, PREAMBLE, PAYLOAD, GUARD; transitions occur only on bit_strobe.
REQ-018 In IDLE at strobe: if mode is FAKE_READER or FAKE_TAG, SHALL start a frame with pattern source; else if live_req, SHALL start with live source; else remain IDLE.
REQ-019 Pattern source SHALL have priority over live_req when both are present at the same strobe.
REQ-020 At frame start SHALL latch source select, enc_dir = (mode == FAKE_READER), dec_en = enc_dir; latched values hold until IDLE.
REQ-021 PREAMBLE SHALL emit PRE_BITS bits of pattern 8'b11110000, MSB first, one per strobe.
REQ-022 PAYLOAD, pattern source, SHALL emit all 400 bits of the 400-bit test pattern, bit 399 first, rotating left by one per strobe.
REQ-023 The pattern rotation pointer SHALL persist across frames; only reset returns it to bit 399.
REQ-024 PAYLOAD, live source, SHALL emit relay_raw sampled at each strobe, until live_req is low at a strobe or LIVE_MAX bits are sent.
REQ-025 live_gnt SHALL be high exactly while the live source holds PREAMBLE/PAYLOAD.
REQ-026 GUARD SHALL emit GUARD_BITS zeros, then assert frame_done for one clk and enter IDLE.
REQ-027 If mode leaves FAKE_READER/FAKE_TAG during a pattern PAYLOAD, SHALL enter GUARD at the next strobe; the pointer stops at its current bit.
REQ-028 enc_bit SHALL be registered, change only on the clk after bit_strobe, and be 0 in IDLE.
REQ-029 Bit counters SHALL be 9 bits wide and saturate, never wrap; count 400 ends the pattern payload.

Reset
REQ-030 While reset is low, SHALL set state IDLE, divider 0, pointer 399, counters 0.
REQ-031 While reset is low, all outputs SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL abort immediately with no frame_done.
REQ-033 After release, the first bit_strobe SHALL occur on the 9th rising clk.

Structure
REQ-034 State encoding, the 400-bit pattern constant, the preamble constant and mode codes SHALL live in a shared relay package/header.
REQ-035 One sub-module relay_bitclk (divider plus strobe) SHALL be instantiated; the FSM and arbitration SHALL stay in relay_sched.

Verification
REQ-036 Mode=FAKE_READER from reset: the first 8 enc_bits SHALL be 11110000, the next 400 SHALL match the pattern from bit 399, then 4 zeros, frame_done at slot 412; enc_dir=dec_en=1.
REQ-037 Mode=FAKE_TAG with live_req=1 at the same strobe: pattern wins, live_gnt=0, enc_dir=0.
REQ-038 Live only, live_req high for 20 strobes with relay_raw alternating: preamble, then 20 payload bits matching relay_raw, guard, frame_done; live_gnt is high for 28 slots.
REQ-039 live_req held high with relay_raw=1: payload stops at exactly 255 bits, then GUARD.
REQ-040 Mode dropped after 100 payload bits: 4 zeros, frame_done; the next frame's payload starts at pattern bit 299.
REQ-041 Reset pulsed mid-PAYLOAD: outputs are 0 immediately, there is no frame_done, and the next frame restarts at bit 399.
